// File: rtl/mul16_rr_scheduler.sv
// Two-requester round-robin front end for a shared iterative shift-add unsigned multiplier.
// One adder step per cycle over W cycles. The product is held registered until the consumer takes it.
module mul16_rr_scheduler #(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [2*W-1:0]   res_data,
    output logic             busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [W-1:0]   mcand;
    logic [2*W-1:0] p;
    logic [CW-1:0]  count;
    logic           owner;
    logic           last_grant;

    logic           grant0;
    logic           grant1;
    logic [W:0]     sum;
    logic [2*W-1:0] p_next;

    // Readies are gated by rst so that every output reads 0 while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    // The sum keeps its carry bit; the shift moves that carry into the top of P.
    always_comb begin
        sum    = {1'b0, p[2*W-1:W]};
        if (p[0]) begin
            sum = {1'b0, p[2*W-1:W]} + {1'b0, mcand};
        end
        p_next = {sum, p[W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mcand      <= {W{1'b0}};
            p          <= {(2*W){1'b0}};
            count      <= {CW{1'b0}};
            owner      <= 1'b0;
            last_grant <= 1'b1;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_data   <= {(2*W){1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        mcand      <= grant1 ? req1_a : req0_a;
                        p          <= {{W{1'b0}}, (grant1 ? req1_b : req0_b)};
                        owner      <= grant1;
                        last_grant <= grant1;
                        count      <= {CW{1'b0}};
                        state      <= RUN;
                    end
                end
                RUN: begin
                    p     <= p_next;
                    count <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= p_next;
                        res_id    <= owner;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        res_id    <= 1'b0;
                        res_data  <= {(2*W){1'b0}};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_rr_scheduler.sv
// Bench for mul16_rr_scheduler: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed products, IDs and latencies.
module tb_mul16_rr_scheduler;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic            req0_ready, req1_ready;
    logic            res_valid, res_ready, res_id, busy;
    logic [2*W-1:0]  res_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mul16_rr_scheduler #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: mode 0 idle, 1 computing (m_left cycles remain), 2 result held.
    logic [1:0]     m_mode;
    int             m_left;
    logic           m_last, m_owner;
    logic [2*W-1:0] m_prod;
    logic           exp_r0, exp_r1;

    assign exp_r0 = !rst && m_mode == 2'd0 && req0_valid && (!req1_valid || m_last);
    assign exp_r1 = !rst && m_mode == 2'd0 && req1_valid && (!req0_valid || !m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= 2'd0;
            m_left  <= 0;
            m_last  <= 1'b1;
            m_owner <= 1'b0;
            m_prod  <= '0;
        end else begin
            case (m_mode)
                2'd0: begin
                    if (exp_r0) begin
                        m_mode <= 2'd1; m_left <= W; m_owner <= 1'b0; m_last <= 1'b0;
                        m_prod <= 32'(req0_a) * 32'(req0_b);
                    end else if (exp_r1) begin
                        m_mode <= 2'd1; m_left <= W; m_owner <= 1'b1; m_last <= 1'b1;
                        m_prod <= 32'(req1_a) * 32'(req1_b);
                    end
                end
                2'd1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_mode <= 2'd2;
                end
                default: if (res_ready) m_mode <= 2'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("req0_ready", 64'(req0_ready), 64'(exp_r0));
        check("req1_ready", 64'(req1_ready), 64'(exp_r1));
        check("res_valid", 64'(res_valid), 64'(m_mode == 2'd2));
        check("busy", 64'(busy), 64'(m_mode != 2'd0));
        if (m_mode == 2'd2) begin
            check("res_id", 64'(res_id), 64'(m_owner));
            check("res_data", 64'(res_data), 64'(m_prod));
        end
    end

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return req0_ready;
            1:       return req1_ready;
            default: return res_valid;
        endcase
    endfunction

    // Returns the cycle number in which the selected signal is first seen high.
    task automatic wait_for(input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel_sig(sel)) begin
                at = cyc;
                break;
            end
        end
        check($sformatf("wait_sel%0d_in_time", sel), 64'(at >= 0), 64'(1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_r0"}, 64'(req0_ready), 64'(0));
        check({tag, "_r1"}, 64'(req1_ready), 64'(0));
        check({tag, "_rv"}, 64'(res_valid), 64'(0));
        check({tag, "_id"}, 64'(res_id), 64'(0));
        check({tag, "_data"}, 64'(res_data), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, tg, tprev, r;
        logic [2*W-1:0] d0;
        logic i0;

        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        step(); step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_all_zero("reset");
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rst = 1'b0;

        // Single op: 3*5
        req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
        wait_for(0, 5, t0);
        step(); req0_valid = 1'b0;
        wait_for(2, 40, t1);
        check("single_latency", 64'(t1 - t0), 64'(17));
        check("single_data", 64'(res_data), 64'(15));
        check("single_id", 64'(res_id), 64'(0));
        step();

        // Max operands on requester 1
        req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
        wait_for(1, 5, t0);
        step(); req1_valid = 1'b0;
        wait_for(2, 40, t1);
        check("max_data", 64'(res_data), 64'h0000_0000_FFFE_0001);
        check("max_id", 64'(res_id), 64'(1));
        check("max_latency", 64'(t1 - t0), 64'(17));
        step();

        // Contention from reset: grants alternate starting with requester 0
        rst = 1'b1; step(); rst = 1'b0;
        req0_valid = 1'b1; req0_a = 16'd7;   req0_b = 16'd9;
        req1_valid = 1'b1; req1_a = 16'd100; req1_b = 16'd200;
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_for(2, 40, t1);
            check($sformatf("cont_id%0d", k), 64'(res_id), 64'(k % 2));
            check($sformatf("cont_data%0d", k), 64'(res_data), (k % 2 == 1) ? 64'(20000) : 64'(63));
            if (k > 0) check($sformatf("cont_spacing%0d", k), 64'(t1 - tprev), 64'(18));
            tprev = t1;
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Backpressure with a request pending from requester 1
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'd255; req0_b = 16'd257;
        wait_for(0, 5, t0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd2; req1_b = 16'd3;
        wait_for(2, 40, t1);
        d0 = res_data; i0 = res_id;
        check("bp_data", 64'(d0), 64'(65535));
        check("bp_id", 64'(i0), 64'(0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(res_valid), 64'(1));
            check("bp_hold_data", 64'(res_data), 64'(d0));
            check("bp_hold_id", 64'(res_id), 64'(i0));
            check("bp_no_ready", 64'(req1_ready), 64'(0));
        end
        step(); res_ready = 1'b1;
        @(negedge clk);
        r = cyc;
        check("bp_release_valid", 64'(res_valid), 64'(1));
        wait_for(1, 3, tg);
        check("bp_grant_cycle", 64'(tg - r), 64'(1));
        step(); req1_valid = 1'b0;
        wait_for(2, 40, t2);
        check("bp_next_data", 64'(res_data), 64'(6));
        check("bp_next_id", 64'(res_id), 64'(1));
        check("bp_next_latency", 64'(t2 - tg), 64'(17));
        step();

        // Reset mid-operation
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0100;
        wait_for(0, 5, t0);
        step(); req0_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd9;
        #1;
        check_all_zero("midrst");
        step(); rst = 1'b0;
        @(negedge clk);
        check("midrst_win0", 64'(req0_ready), 64'(1));
        check("midrst_lose1", 64'(req1_ready), 64'(0));
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        wait_for(2, 40, t1);
        check("midrst_data", 64'(res_data), 64'h0000_0000_0012_3400);
        check("midrst_id", 64'(res_id), 64'(0));
        step();

        // Zero operand still takes the full latency
        req0_valid = 1'b1; req0_a = 16'd0; req0_b = 16'hABCD;
        wait_for(0, 5, t0);
        step(); req0_valid = 1'b0;
        wait_for(2, 40, t1);
        check("zero_latency", 64'(t1 - t0), 64'(17));
        check("zero_data", 64'(res_data), 64'(0));
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
